mul_shiftadd: RTL and testbench

Sequential shift-and-add multiplier, signed or unsigned, one partial-product bit per clock. It is the companion to the subtract-shift divider and uses the same `en`/`done` level-held start protocol, so a CPU or accelerator datapath can share one control sequencer between multiply and divide. Operands are DATA_W bits and the product is the full 2*DATA_W bits.

---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/mul_shiftadd.sv | 96 +++++++++
 tb/tb_mul_shiftadd.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide blocks and their sequencer.
// Holds the latencies and the phase type that decodes the multiplier step counter.
package mul_div_pkg;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ITER,
        PH_SIGN,
        PH_HOLD
    } mul_phase_e;

    function automatic int MUL_LAT(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int DIV_LAT(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/mul_shiftadd.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
// en high starts and holds an operation; done flags a valid product until en falls.
module mul_shiftadd
    import mul_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sign,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int PC_W = $clog2(DATA_W + 3) + 1;

    localparam logic [PC_W-1:0] LOAD     = '0;
    localparam logic [PC_W-1:0] ITER_END = PC_W'(DATA_W);
    localparam logic [PC_W-1:0] SIGN     = PC_W'(DATA_W + 1);
    localparam logic [PC_W-1:0] HOLD     = PC_W'(MUL_LAT(DATA_W));

    logic [PC_W-1:0]   pc;
    logic [2*DATA_W:0] p;
    logic [DATA_W-1:0] a_reg;
    logic              neg;
    logic [DATA_W:0]   sum;
    mul_phase_e        phase;

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is already its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
        return (s & x[DATA_W-1]) ? -x : x;
    endfunction

    always_comb begin
        phase = PH_HOLD;
        if (pc == LOAD)
            phase = PH_LOAD;
        else if (pc <= ITER_END)
            phase = PH_ITER;
        else if (pc == SIGN)
            phase = PH_SIGN;
    end

    // p[2*DATA_W] is the guard bit above the running sum; it is always zero
    // after a shift, so including it is the same as zero-extending.
    assign sum = {p[2*DATA_W], p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, a_reg} : '0);

    // NOTE: state registers use non-blocking assignments so every branch reads
    // the pre-edge values of pc and p, exactly like the hardware flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            p     <= '0;
            done  <= 1'b0;
            a_reg <= '0;
            neg   <= 1'b0;
        end else if (!en) begin
            // NOTE: a_reg and neg are reloaded on every LOAD, so they need no
            // synchronous clear here.
            pc   <= '0;
            p    <= '0;
            done <= 1'b0;
        end else begin
            unique case (phase)
                PH_LOAD: begin
                    a_reg <= mag(multiplicand, sign);
                    p     <= {{(DATA_W + 1){1'b0}}, mag(multiplier, sign)};
                    neg   <= sign & (multiplicand[DATA_W-1] ^ multiplier[DATA_W-1]);
                    pc    <= pc + PC_W'(1);
                end
                PH_ITER: begin
                    p  <= {1'b0, sum, p[DATA_W-1:1]};
                    pc <= pc + PC_W'(1);
                end
                PH_SIGN: begin
                    p[2*DATA_W-1:0] <= neg ? -p[2*DATA_W-1:0] : p[2*DATA_W-1:0];
                    done            <= 1'b1;
                    pc              <= pc + PC_W'(1);
                end
                PH_HOLD: begin
                    pc <= HOLD;
                end
                default: begin
                    pc <= HOLD;
                end
            endcase
        end
    end

    assign product = p[2*DATA_W-1:0];

endmodule

// File: tb/tb_mul_shiftadd.sv
// Self-checking bench for mul_shiftadd (DATA_W=32): a latency/arithmetic model
// checked every cycle, plus directed vectors with hand-computed products.
module tb_mul_shiftadd;
    import mul_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sign = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    mul_shiftadd #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sign         (sign),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{W{a[W-1]}}, a});
            sb = $signed({{W{b[W-1]}}, b});
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Model: counts en-high edges since the block was armed and captures the
    // operands on the first of them; the product is valid from edge LAT on.
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_s = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
        end else if (!en) begin
            m_cnt <= 0;
        end else begin
            if (m_cnt == 0) begin
                m_a <= multiplicand;
                m_b <= multiplier;
                m_s <= sign;
            end
            if (m_cnt < LAT)
                m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic exp_done;
        exp_done = (m_cnt >= LAT);
        check("cyc_done", 64'(done), 64'(exp_done));
        if (exp_done)
            check("cyc_product", product, ref_mul(m_a, m_b, m_s));
    end

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        sign         = s;
        en           = 1'b1;
    endtask

    // Counts edges until done; optionally scrambles the inputs after edge poke.
    task automatic wait_done(input string name, input int poke, input logic [63:0] exp);
        int edges;
        edges = 0;
        while (!done && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == poke) begin
                multiplicand = '0;
                multiplier   = '0;
                sign         = ~sign;
            end
        end
        check({name, "_latency"}, 64'(edges), 64'(LAT));
        check({name, "_product"}, product, exp);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("umax", 0, 64'hFFFF_FFFE_0000_0001);

        start(32'hFFFF_FFF9, 32'd3, 1'b1);
        wait_done("s_m7x3", 0, 64'hFFFF_FFFF_FFFF_FFEB);
        start(32'hFFFF_FFF9, 32'd3, 1'b0);
        wait_done("u_m7x3", 0, 64'h0000_0002_FFFF_FFEB);

        start(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("s_min_sq", 0, 64'h4000_0000_0000_0000);
        start(32'h8000_0000, 32'd1, 1'b1);
        wait_done("s_min_x1", 0, 64'hFFFF_FFFF_8000_0000);

        start(32'd6, 32'd7, 1'b0);
        wait_done("poke", 5, 64'd42);

        // Abort: en is low at edge 10.
        start(32'h1234, 32'h5678, 1'b0);
        repeat (9) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        start(32'd6, 32'd7, 1'b0);
        wait_done("after_abort", 0, 64'd42);

        // Asynchronous reset mid-operation at pc=20, en held high throughout.
        start(32'h1234, 32'h5678, 1'b1);
        repeat (20) @(posedge clk);
        #2;
        rst_n        = 1'b0;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        sign         = 1'b0;
        #1;
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("after_rst", 0, 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
